// File: rtl/line_adapter_pkg.sv
// Shared encodings and FSM state type for the line-to-word memory adapter.
package line_adapter_pkg;

    localparam logic [3:0] MEM_READ       = 4'd0;
    localparam logic [3:0] MEM_WRITE      = 4'd1;
    localparam logic [3:0] MEM_WRITE_INIT = 4'd2;

    localparam int unsigned WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RESP
    } state_e;

    // Both write flavours store the line; everything else is treated as a read.
    function automatic logic is_write_type(input logic [3:0] t);
        return (t == MEM_WRITE) || (t == MEM_WRITE_INIT);
    endfunction

endpackage

// File: rtl/mem_msg_pkg.sv
// Cache memory-port message formats for 16-byte line transfers.
package mem_msg_pkg;

    typedef struct packed {
        logic [3:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [3:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

endpackage

// File: rtl/line_word_capture.sv
// Read-data capture: delays each issued read beat by RD_LAT cycles and assembles
// the returned words into a 128-bit line, word 0 in the low bits.
module line_word_capture
    import line_adapter_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_i,
    input  logic [31:0]                  rdata_i,
    output logic [WORDS_PER_LINE*32-1:0] line_o,
    output logic                         done_o
);

    logic [RD_LAT-1:0]              vld_q, vld_d;
    logic [1:0]                     cnt_q, cnt_d;
    logic [WORDS_PER_LINE*32-1:0]   line_q, line_d;
    logic                           cap;

    if (RD_LAT == 1) begin : g_lat1
        assign vld_d = issue_i;
    end else begin : g_latn
        assign vld_d = {vld_q[RD_LAT-2:0], issue_i};
    end

    assign cap    = vld_q[RD_LAT-1];
    assign done_o = cap && (cnt_q == 2'd3);
    assign line_o = line_q;

    // Store the arriving word into the slot named by the capture counter.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (cap) begin
            line_d[{cnt_q, 5'd0} +: 32] = rdata_i;
            cnt_d                       = cnt_q + 2'd1;
        end
    end

    // Valid pipe, capture counter and line register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            cnt_q  <= 2'd0;
            line_q <= '0;
        end else begin
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/line_word_mem_adapter.sv
// Adapts 16-byte line requests from a cache onto a 32-bit single-port word SRAM,
// four beats per line, one request at a time.
// Optional: define LINE_ADAPTER_ALIGN_CHK_EN to add the sticky err_align output
// and flag misaligned requests with test=2'b01 in their response.
module line_word_mem_adapter
    import mem_msg_pkg::*;
    import line_adapter_pkg::*;
#(
    parameter int unsigned AW     = 10,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  req_msg,
    input  logic          req_val,
    output logic          req_rdy,
    output mem_resp_16B_t resp_msg,
    output logic          resp_val,
    input  logic          resp_rdy,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
`ifdef LINE_ADAPTER_ALIGN_CHK_EN
    ,
    output logic          err_align
`endif
);

    localparam int unsigned BW = AW - 2;
    localparam int unsigned LW = WORDS_PER_LINE * 32;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          issued_q, issued_d;
    logic [3:0]    type_q, type_d;
    logic [7:0]    opaque_q, opaque_d;
    logic [BW-1:0] base_q, base_d;
    logic [LW-1:0] data_q, data_d;
    logic [1:0]    test_q, test_d;
    logic          rdy_en_q;

    logic          req_fire;
    logic          rd_issue;
    logic          cap_done;
    logic          misaligned;
    logic [LW-1:0] cap_line;

    // Address bits above the SRAM and the byte offset never reach the SRAM.
    logic unused_req_bits;
    assign unused_req_bits = ^{req_msg.addr[31:AW+2], req_msg.addr[3:0], req_msg.len};

    assign req_rdy  = (state_q == IDLE) && rdy_en_q;
    assign req_fire = req_val && req_rdy;
    assign rd_issue = (state_q == RD) && !issued_q;
    assign resp_val = (state_q == RESP);

`ifdef LINE_ADAPTER_ALIGN_CHK_EN
    logic err_q, err_d;

    assign misaligned = (req_msg.addr[3:0] != 4'd0) || (req_msg.len != 4'd0);
    assign err_align  = err_q;

    // Sticky misalignment flag, cleared only by reset.
    always_comb begin
        err_d = err_q | (req_fire && misaligned);
    end

    // Error flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // Next-state logic: latch the request, walk four issue beats, wait for the line.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        type_d   = type_q;
        opaque_d = opaque_q;
        base_d   = base_q;
        data_d   = data_q;
        test_d   = test_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    type_d   = req_msg.msg_type;
                    opaque_d = req_msg.opaque;
                    // Upper line-address bits fall off the top of the SRAM.
                    base_d   = req_msg.addr[AW+1:4];
                    data_d   = req_msg.data;
                    test_d   = misaligned ? 2'b01 : 2'b00;
                    cnt_d    = 2'd0;
                    issued_d = 1'b0;
                    state_d  = is_write_type(req_msg.msg_type) ? WR : RD;
                end
            end
            WR: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = RESP;
                end
            end
            RD: begin
                if (!issued_q) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        issued_d = 1'b1;
                    end
                end
                if (cap_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM beat drive and response assembly.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (rd_issue || (state_q == WR)) begin
            sram_ce   = 1'b1;
            sram_addr = {base_q, cnt_q};
        end
        if (state_q == WR) begin
            sram_we    = 1'b1;
            sram_wdata = data_q[{cnt_q, 5'd0} +: 32];
        end

        resp_msg          = '0;
        resp_msg.msg_type = type_q;
        resp_msg.opaque   = opaque_q;
        resp_msg.test     = test_q;
        resp_msg.data     = is_write_type(type_q) ? '0 : cap_line;
    end

    // Main state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            issued_q <= 1'b0;
            type_q   <= 4'd0;
            opaque_q <= 8'd0;
            base_q   <= '0;
            data_q   <= '0;
            test_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            type_q   <= type_d;
            opaque_q <= opaque_d;
            base_q   <= base_d;
            data_q   <= data_d;
            test_q   <= test_d;
        end
    end

    // Holds req_rdy low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    line_word_capture #(
        .RD_LAT (RD_LAT)
    ) u_capture (
        .clk_i   (clk),
        .rst_ni  (reset),
        .issue_i (rd_issue),
        .rdata_i (sram_rdata),
        .line_o  (cap_line),
        .done_o  (cap_done)
    );

endmodule

// File: tb/tb_line_word_mem_adapter.sv
// Bench for line_word_mem_adapter: two instances (RD_LAT=1 and RD_LAT=3) share
// request stimulus; each has its own word SRAM model. Expected responses come
// from a line-granular memory image kept in the bench.
module tb_line_word_mem_adapter;
    import mem_msg_pkg::*;
    import line_adapter_pkg::*;

    localparam int unsigned AW     = 10;
    localparam int unsigned NLINES = 256;
    localparam int unsigned NWORDS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    mem_req_16B_t  req_msg;
    logic          req_val;
    logic          resp_rdy;
    logic          req_rdy    [2];
    mem_resp_16B_t resp_msg   [2];
    logic          resp_val   [2];
    logic          sram_ce    [2];
    logic          sram_we    [2];
    logic [AW-1:0] sram_addr  [2];
    logic [31:0]   sram_wdata [2];
    logic [31:0]   sram_rdata [2];
`ifdef LINE_ADAPTER_ALIGN_CHK_EN
    logic          err_align  [2];
    logic          exp_err;
`endif

    line_word_mem_adapter #(.AW(AW), .RD_LAT(1)) u_dut_lat1 (
        .clk        (clk),
        .reset      (reset),
        .req_msg    (req_msg),
        .req_val    (req_val),
        .req_rdy    (req_rdy[0]),
        .resp_msg   (resp_msg[0]),
        .resp_val   (resp_val[0]),
        .resp_rdy   (resp_rdy),
        .sram_ce    (sram_ce[0]),
        .sram_we    (sram_we[0]),
        .sram_addr  (sram_addr[0]),
        .sram_wdata (sram_wdata[0]),
        .sram_rdata (sram_rdata[0])
`ifdef LINE_ADAPTER_ALIGN_CHK_EN
        ,
        .err_align  (err_align[0])
`endif
    );

    line_word_mem_adapter #(.AW(AW), .RD_LAT(3)) u_dut_lat3 (
        .clk        (clk),
        .reset      (reset),
        .req_msg    (req_msg),
        .req_val    (req_val),
        .req_rdy    (req_rdy[1]),
        .resp_msg   (resp_msg[1]),
        .resp_val   (resp_val[1]),
        .resp_rdy   (resp_rdy),
        .sram_ce    (sram_ce[1]),
        .sram_we    (sram_we[1]),
        .sram_addr  (sram_addr[1]),
        .sram_wdata (sram_wdata[1]),
        .sram_rdata (sram_rdata[1])
`ifdef LINE_ADAPTER_ALIGN_CHK_EN
        ,
        .err_align  (err_align[1])
`endif
    );

    // Word SRAM models; read data is garbage except RD_LAT cycles after a read.
    logic        mem_init;
    logic [31:0] mem  [2][NWORDS];
    logic [31:0] pipe [2][3];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_init) begin
                for (int w = 0; w < NWORDS; w++) begin
                    mem[i][w] <= 32'hC0DE_0000 | 32'(w);
                end
            end else if (sram_ce[i] && sram_we[i]) begin
                mem[i][sram_addr[i]] <= sram_wdata[i];
            end
            pipe[i][0] <= (sram_ce[i] && !sram_we[i]) ? mem[i][sram_addr[i]] : 32'hDEAD_BEEF;
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end

    assign sram_rdata[0] = pipe[0][0];
    assign sram_rdata[1] = pipe[1][2];

    // Reference image of memory, one entry per 16-byte line.
    logic [127:0] ref_line [NLINES];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int i, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic junk_req();
        req_msg.msg_type = 4'($urandom);
        req_msg.opaque   = 8'($urandom);
        req_msg.addr     = $urandom;
        req_msg.len      = 4'($urandom);
        req_msg.data     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One line transaction on both instances, checked cycle by cycle.
    task automatic run_txn(input logic [3:0] t, input logic [31:0] addr, input logic [7:0] op,
                           input logic [3:0] len, input logic [127:0] wdata,
                           input logic [127:0] exp_data, input int hold);
        int          rc     [2];
        bit          fin    [2];
        int          waited;
        int          line;
        int          rc_max;
        bit          is_wr;
        bit          all_fin;
        bit          exp_ce;
        bit          exp_val;
        logic [1:0]  exp_test;
        logic [AW-1:0] ea;

        is_wr = (t == 4'd1) || (t == 4'd2);
        line  = int'((addr >> 4) % NLINES);
        exp_test = 2'b00;
`ifdef LINE_ADAPTER_ALIGN_CHK_EN
        if (addr[3:0] != 4'd0 || len != 4'd0) begin
            exp_test = 2'b01;
        end
`endif
        waited = 0;
        while (!(req_rdy[0] && req_rdy[1]) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("req_rdy_idle", 0, 128'(req_rdy[0] && req_rdy[1]), 128'(1));

        req_msg.msg_type = t;
        req_msg.opaque   = op;
        req_msg.addr     = addr;
        req_msg.len      = len;
        req_msg.data     = wdata;
        req_val          = 1'b1;
        resp_rdy         = (hold == 0);
        rc[0] = is_wr ? 5 : 6;
        rc[1] = is_wr ? 5 : 8;
        rc_max = rc[1];
        fin[0] = 1'b0;
        fin[1] = 1'b0;
        if (is_wr) begin
            ref_line[line] = wdata;
        end
`ifdef LINE_ADAPTER_ALIGN_CHK_EN
        if (exp_test == 2'b01) begin
            exp_err = 1'b1;
        end
`endif

        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_val = 1'b0;
                junk_req();
            end
            all_fin = fin[0] && fin[1];
            for (int i = 0; i < 2; i++) begin
                exp_ce  = (c <= 4);
                exp_val = (c >= rc[i]) && !fin[i];
                check("sram_ce", i, 128'(sram_ce[i]), 128'(exp_ce));
                if (exp_ce) begin
                    ea = AW'(line * 4 + c - 1);
                    check("sram_we", i, 128'(sram_we[i]), 128'(is_wr));
                    check("sram_addr", i, 128'(sram_addr[i]), 128'(ea));
                    if (is_wr) begin
                        check("sram_wdata", i, 128'(sram_wdata[i]), 128'(wdata[32*(c-1) +: 32]));
                    end
                end
                check("resp_val", i, 128'(resp_val[i]), 128'(exp_val));
                check("req_rdy", i, 128'(req_rdy[i]), 128'(fin[i]));
`ifdef LINE_ADAPTER_ALIGN_CHK_EN
                check("err_align", i, 128'(err_align[i]), 128'(exp_err));
`endif
                if (exp_val) begin
                    check("resp_type", i, 128'(resp_msg[i].msg_type), 128'(t));
                    check("resp_opaque", i, 128'(resp_msg[i].opaque), 128'(op));
                    check("resp_test", i, 128'(resp_msg[i].test), 128'(exp_test));
                    check("resp_len", i, 128'(resp_msg[i].len), 128'(0));
                    check("resp_data", i, resp_msg[i].data, exp_data);
                end
            end
            if (all_fin) begin
                break;
            end
            resp_rdy = (hold == 0) || (c >= rc_max + hold);
            for (int i = 0; i < 2; i++) begin
                if ((c >= rc[i]) && !fin[i] && resp_rdy) begin
                    fin[i] = 1'b1;
                end
            end
        end
        check("txn_complete", 0, 128'(fin[0] && fin[1]), 128'(1));
    endtask

    typedef struct {
        logic [3:0]   t;
        logic [31:0]  addr;
        logic [7:0]   op;
        logic [3:0]   len;
        logic [127:0] wdata;
        logic [127:0] exp_data;
        int           hold;
    } vec_t;

    vec_t vecs [7];

    localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_B = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]   t;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] wd;
        logic [127:0] ed;
        int           line;
        int           r;

        vecs[0] = '{MEM_WRITE,      32'h0000_0040, 8'h05, 4'd0, LINE_A, 128'd0, 0};
        vecs[1] = '{MEM_READ,       32'h0000_0040, 8'h0A, 4'd0, 128'd0, LINE_A, 0};
        vecs[2] = '{MEM_READ,       32'h0000_0040, 8'h3C, 4'd0, 128'd0, LINE_A, 10};
        vecs[3] = '{MEM_READ,       32'h0000_0050, 8'h77, 4'd0, 128'd0,
                    128'hC0DE0017_C0DE0016_C0DE0015_C0DE0014, 0};
        vecs[4] = '{MEM_WRITE_INIT, 32'h0000_1230, 8'h11, 4'd0, LINE_B, 128'd0, 2};
        vecs[5] = '{4'd7,           32'h0000_123C, 8'h22, 4'd3, 128'd0, LINE_B, 0};
        vecs[6] = '{MEM_READ,       32'hFFFF_FFF0, 8'hF0, 4'd0, 128'd0,
                    128'hC0DE03FF_C0DE03FE_C0DE03FD_C0DE03FC, 1};

        for (int l = 0; l < NLINES; l++) begin
            for (int k = 0; k < 4; k++) begin
                ref_line[l][32*k +: 32] = 32'hC0DE_0000 + 32'(4 * l + k);
            end
        end
`ifdef LINE_ADAPTER_ALIGN_CHK_EN
        exp_err = 1'b0;
`endif

        // Reset held with a request pending.
        reset    = 1'b0;
        mem_init = 1'b1;
        req_val  = 1'b1;
        resp_rdy = 1'b1;
        junk_req();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("rst_req_rdy", i, 128'(req_rdy[i]), 128'(0));
                check("rst_resp_val", i, 128'(resp_val[i]), 128'(0));
                check("rst_sram_ce", i, 128'(sram_ce[i]), 128'(0));
                check("rst_resp_msg_zero", i, 128'(resp_msg[i] == '0), 128'(1));
                check("rst_sram_addr", i, 128'(sram_addr[i]), 128'(0));
            end
        end
        mem_init = 1'b0;
        req_val  = 1'b0;
        reset    = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rel_req_rdy_pre_edge", i, 128'(req_rdy[i]), 128'(0));
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rel_req_rdy_post_edge", i, 128'(req_rdy[i]), 128'(1));
            check("rel_resp_val", i, 128'(resp_val[i]), 128'(0));
        end

        // Directed vectors.
        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].t, vecs[v].addr, vecs[v].op, vecs[v].len, vecs[v].wdata,
                    vecs[v].exp_data, vecs[v].hold);
        end

        // Reset in cycle 2 of a read.
        req_msg.msg_type = MEM_READ;
        req_msg.opaque   = 8'h66;
        req_msg.addr     = 32'h0000_0040;
        req_msg.len      = 4'd0;
        req_msg.data     = '0;
        req_val          = 1'b1;
        @(negedge clk);
        req_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("mid_rd_ce_c1", i, 128'(sram_ce[i]), 128'(1));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("mid_rst_resp_val", i, 128'(resp_val[i]), 128'(0));
            check("mid_rst_sram_ce", i, 128'(sram_ce[i]), 128'(0));
            check("mid_rst_req_rdy", i, 128'(req_rdy[i]), 128'(0));
        end
        @(negedge clk);
        reset = 1'b1;
`ifdef LINE_ADAPTER_ALIGN_CHK_EN
        exp_err = 1'b0;
`endif
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("post_rst_req_rdy", i, 128'(req_rdy[i]), 128'(1));
            check("post_rst_resp_val", i, 128'(resp_val[i]), 128'(0));
        end
        run_txn(MEM_READ, 32'h0000_0040, 8'h0B, 4'd0, 128'd0, LINE_A, 0);

        // Randomized traffic over a handful of lines.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                2:       t = MEM_WRITE;
                3:       t = MEM_WRITE_INIT;
                5:       t = 4'($urandom_range(3, 15));
                default: t = MEM_READ;
            endcase
            line = ($urandom_range(0, 7) * 37) % NLINES;
            addr = ($urandom & 32'hFFFF_F000) | (32'(line) << 4);
            len  = 4'd0;
            if ($urandom_range(0, 3) == 0) begin
                addr = addr | 32'($urandom_range(0, 15));
                len  = 4'($urandom_range(0, 15));
            end
            wd = {$urandom, $urandom, $urandom, $urandom};
            ed = ((t == 4'd1) || (t == 4'd2)) ? 128'd0 : ref_line[line];
            run_txn(t, addr, 8'($urandom), len, wd, ed, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
